decode_issue_ctrl: RTL and testbench
====================================

// Module: decode_issue_ctrl
// PURPOSE
//  Sequences the decode stage: buffers fetched instructions in a small FIFO and drives the head entry into the
//  combinational decoder (dec_inst -> dec_op). Issues the decoded instruction downstream over a valid/ready handshake.
//  Holds a 32-bit load scoreboard that stalls issue on load-use hazards. Sits between fetch and execute in the pipeline.
// PARAMETERS
//  DEPTH      2   FIFO entries, power of two, >= 2
//  PTR_W      $clog2(DEPTH)   pointer width (derived, do not override)
// PORTS
//  clk          in   1                 clock, all state on rising edge
//  reset        in   1                 asynchronous, active-high reset
//  flush        in   1                 discard all buffered/unissued instructions
//  fetch_valid  in   1                 fetch offers instruction
//  fetch_ready  out  1                 FIFO can accept
//  fetch_inst   in   32                instruction word
//  fetch_pc     in   64                instruction PC
//  dec_inst     out  32                FIFO head instruction to decoder (0 when empty)
//  dec_op       in   instruction_type  decoder result for dec_inst
//  issue_valid  out  1                 head decoded and hazard-free
//  issue_ready  in   1                 execute accepts
//  issue_inst   out  32                head instruction
//  issue_pc     out  64                head PC
//  issue_op     out  instruction_type  = dec_op
//  wb_valid     in   1                 a load result is written back this cycle
//  wb_rd        in   5                 destination of that writeback
//  stall_hazard out  1                 head valid but blocked by scoreboard
// BEHAVIOUR
//  Reset: FIFO empty, head=tail=count=0, scoreboard=0. Outputs: fetch_ready=1, issue_valid=0, stall_hazard=0.
//  Push: fetch_valid & fetch_ready & !flush. fetch_ready = (count < DEPTH); no bypass, so a push into a full FIFO
//   never occurs, even when a pop happens in the same cycle.
//  Pop: issue_valid & issue_ready & !flush. Push and pop in the same cycle: count unchanged, both pointers advance.
//  Latency: an instruction pushed in cycle N can issue in cycle N+1 at the earliest. Pointers wrap modulo DEPTH.
//  Hazard: rs1=inst[19:15], rs2=inst[24:20].
//   rs1 is checked unless op is LUI, AUIPC, JAL or NOP.
//   rs2 is checked only for R-type/W R-type, stores and branches.
//   x0 is never pending.
//   hazard = count>0 & (rs1 used & sb[rs1] | rs2 used & sb[rs2]).
//   issue_valid = count>0 & !hazard & !flush. stall_hazard = count>0 & hazard.
//  Scoreboard: on pop of a load (LB,LH,LW,LD,LBU,LHU,LWU) with rd=inst[11:7] != 0, set sb[rd].
//   wb_valid clears sb[wb_rd].
//   Set and clear of the same rd in one cycle: set wins.
//   Hazard is checked against the registered sb, so a writeback releases the stall the next cycle (no bypass).
//  issue_valid is stable: once asserted it stays high with the same payload until the pop occurs or flush.
//  Flush: next cycle head=tail=count=0; a push or pop in the flush cycle is dropped.
//   The scoreboard is NOT cleared, because issued loads still write back.
//  NOP op (illegal or unknown encoding) issues normally with no scoreboard effect.
//  Reset asserted mid-operation clears all state immediately; any in-flight handshake is lost.
// CONFIGURATION
//  DECODE_STATS_EN defined: adds outputs stat_issued (64) and stat_hazard_cycles (64).
//   stat_issued increments on each pop; stat_hazard_cycles increments each cycle stall_hazard=1.
//   Both reset to 0, are not cleared by flush, and wrap on overflow.
//  DECODE_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  T1 reset: assert reset mid-stream -> fetch_ready=1, issue_valid=0, dec_inst=0 while reset is high.
//  T2 streaming: 4 back-to-back ADDs with issue_ready=1 -> first issue_valid the cycle after the first push,
//   then 1 issue/cycle, PCs in order.
//  T3 full: issue_ready=0, push 3 instrs -> fetch_ready=0 after 2; third is held by fetch until a pop.
//  T4 load-use: LD x5 issues, then ADD x6,x5,x1 -> stall_hazard=1, issue_valid=0 until wb_valid,wb_rd=5;
//   ADD issues the cycle after the writeback.
//  T5 x0/set-wins: LD x0 -> no stall for a dependent op.
//   LD x7 popped in the same cycle as wb_rd=7 -> sb[7] stays 1.
//  T6 flush: 2 buffered instrs, flush=1 with fetch_valid=1 -> count=0 next cycle, nothing issues,
//   pending sb bits are retained.

Source files
------------

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: fetch-to-execute decode stage sequencer.
// A small FIFO of fetched instructions presents its head to an external
// combinational decoder. The decoded result is issued over valid/ready, and a
// 32-entry load scoreboard holds back load-use hazards.
// Optional feature macro: DECODE_STATS_EN (adds issue / hazard-cycle counters).

package decode_issue_pkg;
  typedef enum logic [5:0] {
    NOP,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LD, LBU, LHU, LWU,
    SB, SH, SW, SD,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADDIW, SLLIW, SRLIW, SRAIW,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDW, SUBW, SLLW, SRLW, SRAW
  } instruction_type;
endpackage

module decode_issue_ctrl
  import decode_issue_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [31:0]     fetch_inst,
  input  logic [63:0]     fetch_pc,
  output logic [31:0]     dec_inst,
  input  instruction_type dec_op,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [31:0]     issue_inst,
  output logic [63:0]     issue_pc,
  output instruction_type issue_op,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            stall_hazard
`ifdef DECODE_STATS_EN
  ,
  output logic [63:0]     stat_issued,
  output logic [63:0]     stat_hazard_cycles
`endif
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      inst_mem [DEPTH];
  logic [63:0]      pc_mem   [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic [31:0]      sb_reg, sb_next;

  logic             not_empty;
  logic             push, pop;
  logic             rs1_used, rs2_used, is_load;
  logic             hazard;
  logic [4:0]       rs1, rs2, rd;

  assign not_empty   = (count_reg != '0);
  assign fetch_ready = (count_reg < FULL_COUNT);

  // Head entry is read combinationally so a push in cycle N can issue in N+1.
  assign dec_inst   = not_empty ? inst_mem[head_reg] : 32'd0;
  assign issue_inst = dec_inst;
  assign issue_pc   = not_empty ? pc_mem[head_reg] : 64'd0;
  assign issue_op   = dec_op;

  assign rs1 = dec_inst[19:15];
  assign rs2 = dec_inst[24:20];
  assign rd  = dec_inst[11:7];

  // Classify the decoded op: which source fields are real registers, and loads.
  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    is_load  = 1'b0;
    case (dec_op)
      LUI, AUIPC, JAL, NOP: rs1_used = 1'b0;
      default:              rs1_used = 1'b1;
    endcase
    case (dec_op)
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      ADDW, SUBW, SLLW, SRLW, SRAW,
      SB, SH, SW, SD,
      BEQ, BNE, BLT, BGE, BLTU, BGEU: rs2_used = 1'b1;
      default:                        rs2_used = 1'b0;
    endcase
    case (dec_op)
      LB, LH, LW, LD, LBU, LHU, LWU: is_load = 1'b1;
      default:                       is_load = 1'b0;
    endcase
  end

  // Hazard uses the registered scoreboard only: a writeback frees the stall a cycle later.
  assign hazard       = not_empty & ((rs1_used & sb_reg[rs1]) | (rs2_used & sb_reg[rs2]));
  assign issue_valid  = not_empty & ~hazard & ~flush;
  assign stall_hazard = not_empty & hazard;

  assign push = fetch_valid & fetch_ready & ~flush;
  assign pop  = issue_valid & issue_ready;

  // Scoreboard next state: per-register set on load pop, clear on writeback, set wins.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign sb_next[gi] = 1'b0;
      end else begin : g_xn
        logic set_bit, clr_bit;
        assign set_bit     = pop & is_load & (rd == 5'(gi));
        assign clr_bit     = wb_valid & (wb_rd == 5'(gi));
        assign sb_next[gi] = set_bit | (sb_reg[gi] & ~clr_bit);
      end
    end
  endgenerate

  // FIFO pointer/occupancy next state; flush empties the queue and drops this cycle's handshakes.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) tail_next = tail_reg + 1'b1;
      if (pop)  head_next = head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      sb_reg    <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      sb_reg    <= sb_next;
    end
  end

  // Entry storage: payload only, validity is tracked by the pointers so no reset is needed.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (tail_reg == PTR_W'(gi))) begin
          inst_mem[gi] <= fetch_inst;
          pc_mem[gi]   <= fetch_pc;
        end
      end
    end
  endgenerate

`ifdef DECODE_STATS_EN
  logic [63:0] stat_issued_reg, stat_hazard_reg;

  // Free-running wrap-around counters; flush leaves them untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued_reg <= '0;
      stat_hazard_reg <= '0;
    end else begin
      if (pop)          stat_issued_reg <= stat_issued_reg + 64'd1;
      if (stall_hazard) stat_hazard_reg <= stat_hazard_reg + 64'd1;
    end
  end

  assign stat_issued        = stat_issued_reg;
  assign stat_hazard_cycles = stat_hazard_reg;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed testbench for decode_issue_ctrl with a small reference decoder
// feeding dec_op from dec_inst.
module tb_decode_issue_ctrl;
  import decode_issue_pkg::*;

  logic            clk = 1'b0;
  logic            reset, flush, fetch_valid, fetch_ready;
  logic [31:0]     fetch_inst, dec_inst, issue_inst;
  logic [63:0]     fetch_pc, issue_pc;
  instruction_type dec_op, issue_op;
  logic            issue_valid, issue_ready, wb_valid, stall_hazard;
  logic [4:0]      wb_rd;
`ifdef DECODE_STATS_EN
  logic [63:0]     stat_issued, stat_hazard_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  decode_issue_ctrl #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
    .dec_inst(dec_inst), .dec_op(dec_op),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_inst(issue_inst), .issue_pc(issue_pc), .issue_op(issue_op),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_hazard(stall_hazard)
`ifdef DECODE_STATS_EN
    , .stat_issued(stat_issued), .stat_hazard_cycles(stat_hazard_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference decoder for the handful of encodings used here.
  function automatic instruction_type decode(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = w[6:0];
    f3  = w[14:12];
    case (opc)
      7'h33:   decode = (f3 == 3'd0 && w[31:25] == 7'd0) ? ADD : NOP;
      7'h03:   decode = (f3 == 3'd3) ? LD : (f3 == 3'd2) ? LW : NOP;
      7'h23:   decode = (f3 == 3'd3) ? SD : NOP;
      7'h13:   decode = (f3 == 3'd0) ? ADDI : NOP;
      7'h37:   decode = LUI;
      default: decode = NOP;
    endcase
  endfunction

  always_comb dec_op = decode(dec_inst);

  function automatic logic [31:0] enc_add(input logic [4:0] rd, rs1, rs2);
    enc_add = {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_ld(input logic [4:0] rd, rs1);
    enc_ld = {12'd0, rs1, 3'b011, rd, 7'h03};
  endfunction
  function automatic logic [31:0] enc_sd(input logic [4:0] rs2, rs1);
    enc_sd = {7'd0, rs2, rs1, 3'b011, 5'd0, 7'h23};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    enc_addi = {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    enc_lui = {imm, rd, 7'h37};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc);
    fetch_valid = v;
    fetch_inst  = inst;
    fetch_pc    = pc;
  endtask

  // One line per issued instruction.
  always @(posedge clk) begin
    if (!reset && issue_valid && issue_ready)
      $display("issue pc=0x%0h inst=0x%08h op=%s", issue_pc, issue_inst, issue_op.name());
  end

  initial begin
    reset = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0;
    drive(1'b0, 32'd0, 64'd0);

    // T1a: state while held in reset
    #2;
    check_val("rst_fetch_ready", fetch_ready, 1);
    check_val("rst_issue_valid", issue_valid, 0);
    check_val("rst_stall", stall_hazard, 0);
    check_val("rst_dec_inst", dec_inst, 0);
    tick(); tick();
    reset = 1'b0;

    // T2: four back-to-back ADDs
    issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, enc_add(5'd1, 5'd2, 5'd3), 64'h100 + 64'(4 * i));
      #1;
      if (i == 0) begin
        check_val("t2_first_empty", issue_valid, 0);
      end else begin
        check_val("t2_valid", issue_valid, 1);
        check_val("t2_pc", issue_pc, 64'h100 + 64'(4 * (i - 1)));
        check_val("t2_op", issue_op, ADD);
      end
      tick();
    end
    check_val("t2_drained", issue_valid, 0);

    // T3: full FIFO, third instruction held by fetch
    issue_ready = 1'b0;
    drive(1'b1, enc_add(5'd1, 5'd2, 5'd3), 64'h200); #1;
    check_val("t3_ready0", fetch_ready, 1);
    tick();
    drive(1'b1, enc_add(5'd1, 5'd2, 5'd3), 64'h204); #1;
    check_val("t3_ready1", fetch_ready, 1);
    tick();
    drive(1'b1, enc_add(5'd1, 5'd2, 5'd3), 64'h208); #1;
    check_val("t3_full", fetch_ready, 0);
    check_val("t3_head_pc", issue_pc, 64'h200);
    tick();
    issue_ready = 1'b1; #1;
    check_val("t3_no_bypass", fetch_ready, 0);
    check_val("t3_stable_pc", issue_pc, 64'h200);
    tick(); #1;
    check_val("t3_ready_again", fetch_ready, 1);
    check_val("t3_pc2", issue_pc, 64'h204);
    tick();
    drive(1'b0, 32'd0, 64'd0); #1;
    check_val("t3_pc3", issue_pc, 64'h208);
    tick(); #1;
    check_val("t3_empty", issue_valid, 0);

    // T4: load-use stall released the cycle after writeback
    drive(1'b1, enc_ld(5'd5, 5'd1), 64'h300); tick();
    drive(1'b1, enc_add(5'd6, 5'd5, 5'd1), 64'h304); #1;
    check_val("t4_ld_op", issue_op, LD);
    check_val("t4_ld_pc", issue_pc, 64'h300);
    tick();
    drive(1'b0, 32'd0, 64'd0); #1;
    check_val("t4_stall", stall_hazard, 1);
    check_val("t4_blocked", issue_valid, 0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd5; #1;
    check_val("t4_stall_wb_cycle", stall_hazard, 1);
    tick();
    wb_valid = 1'b0; #1;
    check_val("t4_released", issue_valid, 1);
    check_val("t4_released_pc", issue_pc, 64'h304);
    check_val("t4_no_stall", stall_hazard, 0);
    tick();

    // T5: LD x0 never creates a hazard; set wins over same-cycle clear
    drive(1'b1, enc_ld(5'd0, 5'd1), 64'h400); tick();
    drive(1'b1, enc_add(5'd6, 5'd0, 5'd2), 64'h404); tick();
    drive(1'b0, 32'd0, 64'd0); #1;
    check_val("t5_x0_valid", issue_valid, 1);
    check_val("t5_x0_pc", issue_pc, 64'h404);
    check_val("t5_x0_stall", stall_hazard, 0);
    tick();
    drive(1'b1, enc_ld(5'd7, 5'd1), 64'h408); tick();
    drive(1'b0, 32'd0, 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd7; #1;
    check_val("t5_ld7_valid", issue_valid, 1);
    tick();
    wb_valid = 1'b0;
    drive(1'b1, enc_add(5'd8, 5'd7, 5'd0), 64'h40c); tick();
    drive(1'b1, enc_add(5'd9, 5'd1, 5'd2), 64'h410); #1;
    check_val("t5_setwins_stall", stall_hazard, 1);
    check_val("t5_setwins_blocked", issue_valid, 0);
    tick();

    // T6: flush with fetch_valid high; scoreboard retained
    drive(1'b1, enc_add(5'd9, 5'd1, 5'd2), 64'h414);
    flush = 1'b1; #1;
    check_val("t6_flush_valid", issue_valid, 0);
    check_val("t6_full", fetch_ready, 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 64'd0); #1;
    check_val("t6_dec_empty", dec_inst, 0);
    check_val("t6_none", issue_valid, 0);
    check_val("t6_ready", fetch_ready, 1);
    check_val("t6_stall", stall_hazard, 0);
    drive(1'b1, enc_sd(5'd7, 5'd1), 64'h500); tick();
    drive(1'b0, 32'd0, 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd7; #1;
    check_val("t6_sb_kept_rs2", stall_hazard, 1);
    tick();
    wb_valid = 1'b0; #1;
    check_val("t6_sd_valid", issue_valid, 1);
    check_val("t6_sd_pc", issue_pc, 64'h500);
    tick();

    // Unused source fields: LUI rs1 bits and ADDI rs2 bits name a pending reg
    drive(1'b1, enc_ld(5'd9, 5'd1), 64'h600); tick();
    drive(1'b1, enc_lui(5'd10, {12'd0, 5'd9, 3'd0}), 64'h604); tick();
    drive(1'b1, enc_addi(5'd11, 5'd1, 12'd9), 64'h608); #1;
    check_val("lui_valid", issue_valid, 1);
    check_val("lui_pc", issue_pc, 64'h604);
    tick();
    drive(1'b0, 32'd0, 64'd0); #1;
    check_val("addi_valid", issue_valid, 1);
    check_val("addi_pc", issue_pc, 64'h608);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd9; tick();
    wb_valid = 1'b0;

    // T1b: asynchronous reset mid-stream clears FIFO and scoreboard
    drive(1'b1, enc_ld(5'd12, 5'd1), 64'h700); tick();
    drive(1'b1, enc_add(5'd13, 5'd1, 5'd2), 64'h704); tick();
    issue_ready = 1'b0;
    drive(1'b1, enc_add(5'd13, 5'd1, 5'd2), 64'h708); #1;
    check_val("t1_pre_valid", issue_valid, 1);
    reset = 1'b1; #1;
    check_val("t1_mid_fetch_ready", fetch_ready, 1);
    check_val("t1_mid_issue_valid", issue_valid, 0);
    check_val("t1_mid_dec_inst", dec_inst, 0);
    tick();
    reset = 1'b0;
    issue_ready = 1'b1;
    drive(1'b1, enc_add(5'd14, 5'd12, 5'd0), 64'h70c); tick();
    drive(1'b0, 32'd0, 64'd0); #1;
    check_val("t1_sb_cleared", stall_hazard, 0);
    check_val("t1_post_valid", issue_valid, 1);
    check_val("t1_post_pc", issue_pc, 64'h70c);
    tick(); #1;
    check_val("t1_post_empty", issue_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
